// File: rtl/state_machine_pkg.sv
// Shared types and helpers for the state_machine pattern generator.
//
// Contents:
//   state_t          two-state Moore encoding (S_HIGH drives out=1, S_LOW drives out=0)
//   ZERO_CYCLES_MAX  upper bound on the number of low cycles per period
//   state_out()      Moore output decode, used by the top-level output assign
package state_machine_pkg;

  typedef enum logic [0:0] {
    S_HIGH = 1'b0,
    S_LOW  = 1'b1
  } state_t;

  localparam int ZERO_CYCLES_MAX = 255;

  function automatic logic state_out(state_t s);
    return (s == S_HIGH);
  endfunction

endpackage

// File: rtl/sm_low_counter.sv
// Low-cycle counter for state_machine.
//
// Counts low cycles already emitted in the current period. It never wraps;
// only clr (driven on the S_LOW terminal compare and while in S_HIGH) or
// reset returns it to zero.
//
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous active-high reset, clears the count
//   clr    in  1  clear the count at the next edge (has priority over inc)
//   inc    in  1  increment the count at the next edge
//   last   out 1  count equals ZERO_CYCLES-1 (final low cycle of the period)
//
// Optional: STATE_MACHINE_ASSERT_EN compiles in a range assertion on the count.
module sm_low_counter
  import state_machine_pkg::*;
#(
  parameter int ZERO_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(ZERO_CYCLES + 1);

  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(ZERO_CYCLES - 1));

`ifdef STATE_MACHINE_ASSERT_EN
  a_cnt_range: assert property (@(posedge clk) cnt_q < CW'(ZERO_CYCLES))
    else $error("sm_low_counter: count out of range");
`endif

endmodule

// File: rtl/state_machine.sv
// Free-running Moore pattern generator.
//
// After reset emits one high cycle followed by ZERO_CYCLES low cycles,
// repeating forever (default 1,0,0,1,0,0,...). The output is decoded from the
// registered state only, so it is glitch-free with respect to clk. Both the
// state and the low counter carry declaration initializers, so out reads 1
// before any clock edge even without a reset.
//
// Parameters:
//   ZERO_CYCLES  low cycles between successive high cycles, legal 1..255
//
// Ports:
//   clk    in  1  system clock, rising-edge active
//   reset  in  1  synchronous active-high reset, forces S_HIGH / count 0
//   out    out 1  pattern output
//
// Optional: STATE_MACHINE_ASSERT_EN compiles in simulation-only assertions
// (state legality, period check, reset response) and an elaboration-time
// range check on ZERO_CYCLES. Without it the logic is identical.
module state_machine
  import state_machine_pkg::*;
#(
  parameter int ZERO_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic out
);

  state_t state_q = S_HIGH;
  state_t state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  sm_low_counter #(
    .ZERO_CYCLES(ZERO_CYCLES)
  ) u_low_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  // The counter is cleared whenever the next state is (or passes through)
  // a period boundary, so it always starts at 0 on entry to S_LOW.
  always_comb begin
    state_d = S_HIGH;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_HIGH: begin
        state_d = S_LOW;
        cnt_clr = 1'b1;
      end
      S_LOW: begin
        if (cnt_last) begin
          state_d = S_HIGH;
          cnt_clr = 1'b1;
        end else begin
          state_d = S_LOW;
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = S_HIGH;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HIGH;
    end else begin
      state_q <= state_d;
    end
  end

  assign out = state_out(state_q);

`ifdef STATE_MACHINE_ASSERT_EN
  if (ZERO_CYCLES < 1 || ZERO_CYCLES > ZERO_CYCLES_MAX) begin : g_bad_param
    $fatal(1, "state_machine: ZERO_CYCLES out of range 1..255");
  end

  // Independent phase tracker: edges since the last reset, modulo the period.
  int unsigned phase_q = 0;
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 0;
    end else if (phase_q == int'(ZERO_CYCLES)) begin
      phase_q <= 0;
    end else begin
      phase_q <= phase_q + 1;
    end
  end

  a_state_legal: assert property (@(posedge clk) state_q inside {S_HIGH, S_LOW})
    else $error("state_machine: illegal state");
  a_period: assert property (@(posedge clk) out == (phase_q == 0))
    else $error("state_machine: output out of period");
  a_reset_high: assert property (@(posedge clk) reset |=> out)
    else $error("state_machine: out not high after reset");
`endif

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine: three instances (ZERO_CYCLES = 2, 1, 4)
// share one clock and one reset; outputs are compared as a 3-bit vector
// {z4, z1, z2} against hand-computed patterns, sampled 1 time unit after
// each rising edge.
module tb_state_machine;

  logic clk = 1'b0;
  logic reset;
  logic out_z2, out_z1, out_z4;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  always #5 clk = ~clk;

  state_machine #(.ZERO_CYCLES(2)) dut_z2 (.clk(clk), .reset(reset), .out(out_z2));
  state_machine #(.ZERO_CYCLES(1)) dut_z1 (.clk(clk), .reset(reset), .out(out_z1));
  state_machine #(.ZERO_CYCLES(4)) dut_z4 (.clk(clk), .reset(reset), .out(out_z4));

  logic [2:0] outs;
  assign outs = {out_z4, out_z1, out_z2};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_power_up();
    #1;
    assert_cnt++;
    if (outs !== 3'b111) begin
      fail_cnt++;
      $display("FAIL power_up_t0: got %b expected 111", outs);
    end
    step();
    assert_cnt++;
    if (outs !== 3'b000) begin
      fail_cnt++;
      $display("FAIL power_up_edge1: got %b expected 000", outs);
    end
  endtask

  // Edge k after reset, bit k-1 of each pattern.
  task automatic test_reset();
    logic [5:0] exp_z2, exp_z1, exp_z4;
    exp_z2 = 6'b100100;
    exp_z1 = 6'b101010;
    exp_z4 = 6'b010000;
    reset = 1'b1;
    step();
    assert_cnt++;
    if (outs !== 3'b111) begin
      fail_cnt++;
      $display("FAIL reset_state: got %b expected 111", outs);
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      assert_cnt++;
      if (outs !== {exp_z4[k-1], exp_z1[k-1], exp_z2[k-1]}) begin
        fail_cnt++;
        $display("FAIL reset_seq edge %0d: got %b expected %b", k, outs,
                 {exp_z4[k-1], exp_z1[k-1], exp_z2[k-1]});
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] exp_z2, exp_z1, exp_z4;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    assert_cnt++;
    if (out_z2 !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mid_reset_pre: got %b expected 0", out_z2);
    end
    reset = 1'b1;
    step();
    assert_cnt++;
    if (outs !== 3'b111) begin
      fail_cnt++;
      $display("FAIL mid_reset_hit: got %b expected 111", outs);
    end
    reset = 1'b0;
    exp_z2 = 3'b100;
    exp_z1 = 3'b010;
    exp_z4 = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      step();
      assert_cnt++;
      if (outs !== {exp_z4[k-1], exp_z1[k-1], exp_z2[k-1]}) begin
        fail_cnt++;
        $display("FAIL mid_reset_seq edge %0d: got %b expected %b", k, outs,
                 {exp_z4[k-1], exp_z1[k-1], exp_z2[k-1]});
      end
    end
  endtask

  task automatic test_reset_held();
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      assert_cnt++;
      if (outs !== 3'b111) begin
        fail_cnt++;
        $display("FAIL reset_held edge %0d: got %b expected 111", k, outs);
      end
    end
    reset = 1'b0;
    step();
    assert_cnt++;
    if (outs !== 3'b000) begin
      fail_cnt++;
      $display("FAIL reset_release: got %b expected 000", outs);
    end
  endtask

  // Long run: checks the counter terminal compare over several periods.
  task automatic test_long_run();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic [2:0] e;
      e = {(k % 5) == 0, (k % 2) == 0, (k % 3) == 0};
      step();
      assert_cnt++;
      if (outs !== e) begin
        fail_cnt++;
        $display("FAIL long_run edge %0d: got %b expected %b", k, outs, e);
      end
    end
  endtask

  task automatic test_random_reset();
    int unsigned since;
    logic [2:0]  e;
    reset = 1'b1;
    step();
    since = 0;
    for (int k = 0; k < 100; k++) begin
      reset = ($urandom_range(0, 9) == 0);
      step();
      if (reset) since = 0;
      else since++;
      e = {(since % 5) == 0, (since % 2) == 0, (since % 3) == 0};
      assert_cnt++;
      if (outs !== e) begin
        fail_cnt++;
        $display("FAIL random_reset edge %0d: got %b expected %b", k, outs, e);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    test_power_up();
    test_reset();
    test_mid_reset();
    test_reset_held();
    test_long_run();
    test_random_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
